dma_onchip_copy_master: RTL and testbench
=========================================

Name: dma_onchip_copy_master

Overview:
- Avalon-MM master that drives one port of the dual-port on-chip RAM: address, byteenable, chipselect, write, writedata in; readdata out.
- Copies a block of 32-bit words from a source word address to a destination word address in that RAM, one word at a time.
- Started by the DMA control logic through a start/done handshake.
- The other RAM port stays free for the processor.

Parameters:
- ADDR_W, 11, word-address width; matches a 2048-word RAM.
- DATA_W, 32, data width; byteenable is DATA_W/8 bits.
- LEN_W, 12, transfer-length width; must hold 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address, latched on start
- dst_addr  in  ADDR_W  first destination word address, latched on start
- length  in  LEN_W  number of words to copy, latched on start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at end of transfer
- error  out  1  one-cycle pulse, same cycle as done, when length > 2**ADDR_W
- words_left  out  LEN_W  words not yet written
- address  out  ADDR_W  memory word address
- byteenable  out  DATA_W/8  memory byte enables; all ones whenever chipselect is high
- chipselect  out  1  memory select
- write  out  1  memory write strobe
- debugaccess  out  1  memory write qualifier; equals write, because the RAM gates wren with debugaccess
- writedata  out  DATA_W  memory write data
- readdata  in  DATA_W  memory read data; fixed read latency 1 (registered address, unregistered q)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-transfer aborts immediately. No done pulse; the partial copy remains in memory.
- Memory clock enable is tied high by the integrator; no waitrequest exists on this interface.
- FSM states: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - start=1 latches src, dst, length and loads words_left=length.
  - length=0 or length>2**ADDR_W goes to FIN with no memory access.
  - Any other length goes to RD.
- RD: drive address=src_ptr, chipselect=1, write=0. Go to CAP.
- CAP: readdata is valid this cycle; register it into the data latch. chipselect=0. Go to WR.
- WR:
  - Drive address=dst_ptr, chipselect=1, write=1, debugaccess=1, writedata=latch.
  - Increment src_ptr and dst_ptr modulo 2**ADDR_W (wrap 2047 -> 0).
  - Decrement words_left.
  - If words_left was 1, go to FIN; otherwise go to RD.
- FIN: done=1 for exactly one cycle. error=1 in that cycle if the oversize condition held. busy=0. Go to IDLE.
- Throughput: 3 cycles per word. Latency from start to done = 3*N+2 cycles for N>0; 2 cycles for N=0.
- start while busy is ignored and not queued. start in the FIN cycle is also ignored.
- Overlap: copy is strictly ascending. If dst lies in (src, src+N), already-written words are re-read; the result is replicated data. This is defined behaviour, not an error.
- address, byteenable and writedata hold their last values when chipselect=0; a bench must not check them then.

Optional Feature:
- Macro: DMA_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0].
  - Cleared to 0 on an accepted start and on reset.
  - Each word captured in CAP is added modulo 2**DATA_W.
  - Final value is stable from FIN until the next accepted start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- RAM[0..3]=0x11111111,0x22222222,0x33333333,0x44444444; start src=0 dst=100 len=4
  -> RAM[100..103] hold the same values; done pulses 14 cycles after start; busy high for 13 cycles; error=0. With the macro, checksum=0xAAAAAAAA.
- len=0 -> no chipselect at any cycle; done pulses 2 cycles after start; error=0.
- len=3000 -> no chipselect; done and error pulse together; words_left returns to 0.
- src=2046 dst=10 len=4 with RAM[2046]=A, RAM[2047]=B, RAM[0]=C, RAM[1]=D
  -> RAM[10..13]=A,B,C,D; read addresses wrap 2047 -> 0.
- Second start asserted mid-transfer with different args -> ignored; only the first copy executes; exactly one done pulse.
- reset asserted in the WR cycle of word 2 of 5 -> outputs 0 immediately; only words 0..1 (plus possibly word 2) written; no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/dma_onchip_copy_master.sv
// Avalon-MM master that copies a block of words inside a dual-port on-chip RAM.
// Optional running checksum of copied words when DMA_COPY_CHECKSUM_EN is defined.
module dma_onchip_copy_master #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_W-1:0]    words_left,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic                debugaccess,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata
`ifdef DMA_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(2 ** ADDR_W);
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] src_ptr_r;
  logic [ADDR_W-1:0] dst_ptr_r;
  logic [ADDR_W-1:0] src_nxt_s;
  logic [ADDR_W-1:0] dst_nxt_s;
  logic [LEN_W-1:0]  left_nxt_s;
  logic              oversize_r;
  logic              oversize_nxt_s;
  logic              accept_s;
  logic              cs_nxt_s;
  logic              wr_nxt_s;

  // Next-state, pointer and counter decode
  always_comb begin
    state_nxt_s    = state_r;
    src_nxt_s      = src_ptr_r;
    dst_nxt_s      = dst_ptr_r;
    left_nxt_s     = words_left;
    oversize_nxt_s = oversize_r;
    accept_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s       = 1'b1;
          src_nxt_s      = src_addr;
          dst_nxt_s      = dst_addr;
          left_nxt_s     = length;
          oversize_nxt_s = (length > MAX_LEN);
          if ((length == LEN_ZERO) || (length > MAX_LEN)) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        state_nxt_s = CAP;
      end
      CAP: begin
        state_nxt_s = WR;
      end
      WR: begin
        // Pointers wrap naturally at 2**ADDR_W
        src_nxt_s  = src_ptr_r + PTR_ONE;
        dst_nxt_s  = dst_ptr_r + PTR_ONE;
        left_nxt_s = words_left - LEN_ONE;
        if (words_left == LEN_ONE) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RD;
        end
      end
      FIN: begin
        left_nxt_s     = LEN_ZERO;
        oversize_nxt_s = 1'b0;
        state_nxt_s    = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory strobes are decoded from the next state so they align with RD/WR
  always_comb begin
    cs_nxt_s = 1'b0;
    wr_nxt_s = 1'b0;
    if ((state_nxt_s == RD) || (state_nxt_s == WR)) begin
      cs_nxt_s = 1'b1;
    end else begin
      cs_nxt_s = 1'b0;
    end
    if (state_nxt_s == WR) begin
      wr_nxt_s = 1'b1;
    end else begin
      wr_nxt_s = 1'b0;
    end
  end

  // State, pointer and length bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      src_ptr_r  <= {ADDR_W{1'b0}};
      dst_ptr_r  <= {ADDR_W{1'b0}};
      words_left <= LEN_ZERO;
      oversize_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      src_ptr_r  <= src_nxt_s;
      dst_ptr_r  <= dst_nxt_s;
      words_left <= left_nxt_s;
      oversize_r <= oversize_nxt_s;
    end
  end

  // Registered memory-port outputs; address/data hold while deselected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address     <= {ADDR_W{1'b0}};
      byteenable  <= {BE_W{1'b0}};
      chipselect  <= 1'b0;
      write       <= 1'b0;
      debugaccess <= 1'b0;
      writedata   <= {DATA_W{1'b0}};
    end else begin
      chipselect  <= cs_nxt_s;
      write       <= wr_nxt_s;
      debugaccess <= wr_nxt_s;
      if (state_nxt_s == RD) begin
        address    <= src_nxt_s;
        byteenable <= {BE_W{1'b1}};
      end else if (state_nxt_s == WR) begin
        address    <= dst_nxt_s;
        byteenable <= {BE_W{1'b1}};
      end else begin
        address    <= address;
        byteenable <= byteenable;
      end
      // readdata is valid in CAP; writedata doubles as the data latch
      if (state_r == CAP) begin
        writedata <= readdata;
      end else begin
        writedata <= writedata;
      end
    end
  end

  // Handshake outputs: done/error follow the FIN state by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      busy  <= (state_nxt_s != IDLE);
      done  <= (state_r == FIN);
      error <= (state_r == FIN) && oversize_r;
    end
  end

`ifdef DMA_COPY_CHECKSUM_EN
  // Running modulo-2**DATA_W sum of every captured word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      checksum <= {DATA_W{1'b0}};
    end else if (state_r == CAP) begin
      checksum <= checksum + readdata;
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule

// File: tb/tb_dma_onchip_copy_master.sv
// Scoreboard bench for dma_onchip_copy_master with a behavioural dual-port RAM.
// Expected reads/writes are queued at start and popped as the DUT issues them.
module tb_dma_onchip_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] src_addr;
  logic [10:0] dst_addr;
  logic [11:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] words_left;
  logic [10:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic        debugaccess;
  logic [31:0] writedata;
  logic [31:0] readdata;
`ifdef DMA_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  dma_onchip_copy_master dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error), .words_left(words_left),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .debugaccess(debugaccess), .writedata(writedata),
    .readdata(readdata)
`ifdef DMA_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // RAM: registered address, unregistered q; second port used for preload
  logic [31:0] mem [0:2047];
  logic [31:0] shadow [0:2047];
  logic [10:0] addr_q = 11'd0;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (chipselect && write && debugaccess) mem[address] <= writedata;
    if (chipselect) addr_q <= address;
  end
  assign readdata = mem[addr_q];

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] rd_q[$];
  logic [10:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] exp_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every memory access must match the head of its queue
  always @(negedge clk) begin
    if (!reset && chipselect) begin
      check("be_all_ones", byteenable, 4'hF);
      check("dbg_eq_wr", debugaccess, write);
      if (write) begin
        if (wa_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", address, wa_q.pop_front());
          check("wr_data", writedata, wd_q.pop_front());
        end
      end else begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", address, rd_q.pop_front());
      end
    end
  end

  task automatic put(input int a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 11'(a); pre_data = v;
    shadow[a] = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic push_exp(input int s, input int d, input int n);
    logic [31:0] v;
    exp_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      v = shadow[(s + i) % 2048];
      shadow[(d + i) % 2048] = v;
      exp_sum += v;
      rd_q.push_back(11'((s + i) % 2048));
      wa_q.push_back(11'((d + i) % 2048));
      wd_q.push_back(v);
    end
  endtask

  task automatic run_copy(input int s, input int d, input int n, input int inj_at,
                          output int lat, output int bcnt, output int ndone,
                          output logic errv, output logic csv);
    lat = -1; bcnt = 0; ndone = 0; errv = 1'b0; csv = 1'b0;
    if (n >= 1 && n <= 2048) push_exp(s, d, n);
    @(negedge clk);
    src_addr = 11'(s); dst_addr = 11'(d); length = 12'(n); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 20000; k++) begin
      @(negedge clk);
      if (k == inj_at) begin
        start = 1'b1; src_addr = 11'd500; dst_addr = 11'd600; length = 12'd7;
      end else start = 1'b0;
      if (busy) bcnt++;
      if (chipselect) csv = 1'b1;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; errv = error; end
      end
      if (lat >= 0 && k >= lat + 15) break;
    end
    start = 1'b0;
    if (lat < 0) check("done_timeout", 0, 1);
    check("wr_q_drained", wa_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("words_left_end", words_left, 12'd0);
  endtask

  task automatic mem_cmp(input string tag, input int a);
    check(tag, mem[a], shadow[a]);
  endtask

  int lat, bcnt, ndone;
  logic errv, csv;

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = 11'd0; dst_addr = 11'd0; length = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cs", chipselect, 0);
    check("rst_write", write, 0);
    check("rst_dbg", debugaccess, 0);
    check("rst_words_left", words_left, 0);
    check("rst_address", address, 0);
    check("rst_be", byteenable, 0);
    check("rst_wdata", writedata, 0);
    reset = 1'b0;

    // Basic 4-word copy
    put(0, 32'h11111111); put(1, 32'h22222222); put(2, 32'h33333333); put(3, 32'h44444444);
    for (int i = 100; i < 104; i++) put(i, 32'h0);
    run_copy(0, 100, 4, 0, lat, bcnt, ndone, errv, csv);
    check("basic_latency", lat, 14);
    check("basic_busy_cycles", bcnt, 13);
    check("basic_done_count", ndone, 1);
    check("basic_error", errv, 0);
    for (int i = 100; i < 104; i++) mem_cmp("basic_mem", i);
    check("basic_mem_lit", mem[103], 32'h44444444);
`ifdef DMA_COPY_CHECKSUM_EN
    check("basic_checksum", checksum, 32'hAAAAAAAA);
    check("basic_checksum_model", checksum, exp_sum);
`endif

    // Zero length
    run_copy(5, 200, 0, 0, lat, bcnt, ndone, errv, csv);
    check("zero_latency", lat, 2);
    check("zero_no_cs", csv, 0);
    check("zero_error", errv, 0);
    check("zero_busy_cycles", bcnt, 1);

    // Oversize lengths
    run_copy(5, 200, 3000, 0, lat, bcnt, ndone, errv, csv);
    check("over3000_latency", lat, 2);
    check("over3000_error", errv, 1);
    check("over3000_no_cs", csv, 0);
    run_copy(5, 200, 2049, 0, lat, bcnt, ndone, errv, csv);
    check("over2049_error", errv, 1);
    check("over2049_done_count", ndone, 1);

    // Address wrap 2047 -> 0
    put(2046, 32'hAAAA0001); put(2047, 32'hBBBB0002); put(0, 32'hCCCC0003); put(1, 32'hDDDD0004);
    for (int i = 10; i < 14; i++) put(i, 32'h0);
    run_copy(2046, 10, 4, 0, lat, bcnt, ndone, errv, csv);
    check("wrap_latency", lat, 14);
    check("wrap_mem10", mem[10], 32'hAAAA0001);
    check("wrap_mem13", mem[13], 32'hDDDD0004);
    for (int i = 10; i < 14; i++) mem_cmp("wrap_mem", i);

    // Start while busy and start during FIN are ignored
    for (int i = 0; i < 4; i++) put(40 + i, 32'h5A000000 + 32'(i));
    run_copy(40, 60, 4, 5, lat, bcnt, ndone, errv, csv);
    check("ign_busy_done_count", ndone, 1);
    check("ign_busy_cycles", bcnt, 13);
    run_copy(40, 70, 4, 13, lat, bcnt, ndone, errv, csv);
    check("ign_fin_done_count", ndone, 1);
    check("ign_fin_busy_cycles", bcnt, 13);
    mem_cmp("ign_mem", 73);

    // Overlapping copy replicates data
    for (int i = 0; i < 6; i++) put(80 + i, 32'h0B000000 + 32'(i));
    run_copy(80, 82, 4, 0, lat, bcnt, ndone, errv, csv);
    for (int i = 80; i < 86; i++) mem_cmp("overlap_mem", i);

    // Reset in the WR cycle of word 2 of 5
    for (int i = 0; i < 5; i++) put(200 + i, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 5; i++) put(300 + i, 32'hDEAD0000 + 32'(i));
    push_exp(200, 300, 2);
    rd_q.push_back(11'd202);
    @(negedge clk);
    src_addr = 11'd200; dst_addr = 11'd300; length = 12'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_cs", chipselect, 0);
    check("abort_write", write, 0);
    check("abort_busy", busy, 0);
    check("abort_words_left", words_left, 0);
    check("abort_address", address, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_wr_q", wa_q.size(), 0);
    check("abort_rd_q", rd_q.size(), 0);
    for (int i = 300; i < 305; i++) mem_cmp("abort_mem", i);
    check("abort_word2_untouched", mem[302], 32'hDEAD0002);

    // A fresh copy after the abort completes normally
    run_copy(200, 400, 5, 0, lat, bcnt, ndone, errv, csv);
    check("post_abort_latency", lat, 17);
    check("post_abort_done_count", ndone, 1);
    for (int i = 400; i < 405; i++) mem_cmp("post_abort_mem", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
